// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep controller:
// FSM state encoding and sweep-mode constants.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  // The unused encoding 2'b11 behaves as a single-shot sweep.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_SINGLE : m;
  endfunction

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Dwell timer for the sweep FSM: counts 0..limit while enabled and flags
// the terminal count so the FSM knows when a frequency step has expired.
module sweep_dwell_cnt #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [DWELL_WIDTH-1:0] limit_i,
  output logic                   tc_o
);

  logic [DWELL_WIDTH-1:0] cnt_q;

  assign tc_o = (cnt_q == limit_i);

  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller feeding a DDS: steps the frequency word from a
// start to a stop value with a programmable dwell in single/saw/triangle mode.
module dds_sweep_ctrl #(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [PHASE_WIDTH-1:0] start_word,
  input  logic [PHASE_WIDTH-1:0] stop_word,
  input  logic [PHASE_WIDTH-1:0] step_word,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic [PHASE_WIDTH-1:0] phase_offset,
  output logic [PHASE_WIDTH-1:0] Fre_word,
  output logic [PHASE_WIDTH-1:0] Pha_word,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   cfg_err
);

  import dds_pkg::*;

  state_e                 state_q;
  logic [1:0]             mode_q;
  logic [PHASE_WIDTH-1:0] start_q, stop_q, step_q, fre_q, pha_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic                   busy_q, done_q, err_q;

  logic                   cfg_bad, accept, cnt_en, tc;
  logic [PHASE_WIDTH:0]   up_sum;
  logic [PHASE_WIDTH-1:0] up_word, down_word;

  assign cfg_bad = (step_word == '0) || (start_word > stop_word);
  assign accept  = (state_q == IDLE) && start && !stop && !cfg_bad;
  assign cnt_en  = (state_q != IDLE) && !stop;

  // One extra bit on the sum lets the clamp see past the top of the range
  // instead of wrapping; the down step compares the remaining distance.
  assign up_sum    = {1'b0, fre_q} + {1'b0, step_q};
  assign up_word   = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[PHASE_WIDTH-1:0];
  assign down_word = ((fre_q - start_q) < step_q) ? start_q : fre_q - step_q;

  sweep_dwell_cnt #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_i   (accept),
    .en_i    (cnt_en),
    .limit_i (dwell_q),
    .tc_o    (tc)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      mode_q  <= MODE_SINGLE;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      fre_q   <= '0;
      pha_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              mode_q  <= norm_mode(mode);
              start_q <= start_word;
              stop_q  <= stop_word;
              step_q  <= step_word;
              dwell_q <= dwell;
              fre_q   <= start_word;
              pha_q   <= phase_offset;
              busy_q  <= 1'b1;
              state_q <= UP;
            end
          end
        end
        UP: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tc) begin
            if (fre_q != stop_q) begin
              fre_q <= up_word;
            end else begin
              case (mode_q)
                MODE_SAW: begin
                  done_q <= 1'b1;
                  fre_q  <= start_q;
                end
                MODE_TRI: begin
                  // A degenerate triangle has nowhere to turn; each dwell is a pass.
                  if (start_q == stop_q) begin
                    done_q <= 1'b1;
                  end else begin
                    fre_q   <= down_word;
                    state_q <= DOWN;
                  end
                end
                default: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end
              endcase
            end
          end
        end
        DOWN: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tc) begin
            if (fre_q != start_q) begin
              fre_q <= down_word;
            end else begin
              done_q  <= 1'b1;
              fre_q   <= up_word;
              state_q <= UP;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Fre_word   = fre_q;
  assign Pha_word   = pha_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl: inputs change and outputs
// are sampled on the falling edge, expected values are hand-computed.
module tb_dds_sweep_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start, stop;
  logic [1:0]  mode;
  logic [31:0] start_word, stop_word, step_word, phase_offset;
  logic [15:0] dwell;
  logic [31:0] Fre_word, Pha_word;
  logic        busy, sweep_done, cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  dds_sweep_ctrl #(.PHASE_WIDTH(32), .DWELL_WIDTH(16)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .start_word   (start_word),
    .stop_word    (stop_word),
    .step_word    (step_word),
    .dwell        (dwell),
    .phase_offset (phase_offset),
    .Fre_word     (Fre_word),
    .Pha_word     (Pha_word),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .cfg_err      (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [31:0] sw, input logic [31:0] pw,
                         input logic [31:0] st, input logic [15:0] dw, input logic [31:0] ph);
    mode = m; start_word = sw; stop_word = pw; step_word = st; dwell = dw; phase_offset = ph;
  endtask

  // Returns on the falling edge right after the edge that sampled start.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle_flags(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(sweep_done), 32'd0);
    check({tag, "_err"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int exp1[14] = '{100, 100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130, 130, 130};
    int exp2[5]  = '{100, 110, 120, 125, 125};
    int exp3[8]  = '{0, 10, 20, 10, 0, 10, 20, 10};
    logic [31:0] exp5[10] = '{32'hFFFF_FFC0, 32'hFFFF_FFC0, 32'hFFFF_FFE0, 32'hFFFF_FFE0,
                              32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFC0, 32'hFFFF_FFC0,
                              32'hFFFF_FFE0, 32'hFFFF_FFE0};

    rst_in = 1'b1; start = 1'b0; stop = 1'b0;
    set_cfg(2'b00, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_fre", Fre_word, 0);
    check("rst_pha", Pha_word, 0);
    check_idle_flags("rst");
    rst_in = 1'b0;
    tick();

    // 1: single sweep 100..130 step 10, dwell 2; inputs scrambled after accept
    set_cfg(2'b00, 100, 130, 10, 2, 32'h1234_5678);
    pulse_start();
    set_cfg(2'b01, 999, 5, 0, 7, 0);
    check("t1_pha", Pha_word, 32'h1234_5678);
    for (int k = 0; k < 14; k++) begin
      check($sformatf("t1_fre_%0d", k), Fre_word, exp1[k]);
      check($sformatf("t1_busy_%0d", k), 32'(busy), (k < 12) ? 32'd1 : 32'd0);
      check($sformatf("t1_done_%0d", k), 32'(sweep_done), (k == 12) ? 32'd1 : 32'd0);
      tick();
    end

    // 2: clamp at a stop value that is not a multiple of the step
    set_cfg(2'b00, 100, 125, 10, 0, 0);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_fre_%0d", k), Fre_word, exp2[k]);
      check($sformatf("t2_done_%0d", k), 32'(sweep_done), (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("t2_busy_end", 32'(busy), 0);

    // 3: triangle 0..20, then abort while stepping down
    set_cfg(2'b10, 0, 20, 10, 0, 0);
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_fre_%0d", k), Fre_word, exp3[k]);
      check($sformatf("t3_done_%0d", k), 32'(sweep_done), (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("t3_busy_%0d", k), 32'(busy), 1);
      if (k == 7) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    check("t3_abort_fre", Fre_word, 10);
    check_idle_flags("t3_abort");
    tick();
    check("t3_frozen_fre", Fre_word, 10);
    check("t3_frozen_done", 32'(sweep_done), 0);

    // 4: rejected configurations
    set_cfg(2'b00, 50, 40, 10, 0, 0);
    pulse_start();
    check("t4a_err", 32'(cfg_err), 1);
    check("t4a_busy", 32'(busy), 0);
    check("t4a_fre", Fre_word, 10);
    tick();
    check("t4a_err_drop", 32'(cfg_err), 0);
    set_cfg(2'b00, 40, 50, 0, 0, 0);
    pulse_start();
    check("t4b_err", 32'(cfg_err), 1);
    check("t4b_busy", 32'(busy), 0);
    tick();
    check_idle_flags("t4b_after");

    // 5: sawtooth near the top of the range, start while busy, start+stop
    set_cfg(2'b01, 32'hFFFF_FFC0, 32'hFFFF_FFF0, 32'h20, 1, 0);
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t5_fre_%0d", k), Fre_word, exp5[k]);
      check($sformatf("t5_done_%0d", k), 32'(sweep_done), (k == 6) ? 32'd1 : 32'd0);
      check($sformatf("t5_busy_%0d", k), 32'(busy), 1);
      check($sformatf("t5_err_%0d", k), 32'(cfg_err), 0);
      start = (k == 8) || (k == 9);
      stop  = (k == 9);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    check("t5_abort_fre", Fre_word, 32'hFFFF_FFE0);
    check_idle_flags("t5_abort");
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_idle_both_fre", Fre_word, 32'hFFFF_FFE0);
    check_idle_flags("t5_idle_both");

    // 6: reset mid-sweep, then immediate restart
    set_cfg(2'b00, 100, 130, 10, 2, 32'h55);
    pulse_start();
    repeat (4) tick();
    check("t6_pre_fre", Fre_word, 110);
    rst_in = 1'b1;
    tick();
    check("t6_rst_fre", Fre_word, 0);
    check("t6_rst_pha", Pha_word, 0);
    check_idle_flags("t6_rst");
    rst_in = 1'b0;
    tick();
    set_cfg(2'b00, 7, 9, 1, 0, 32'hABCD);
    pulse_start();
    check("t6_restart_fre", Fre_word, 7);
    check("t6_restart_pha", Pha_word, 32'hABCD);
    check("t6_restart_busy", 32'(busy), 1);
    tick();
    check("t6_restart_step", Fre_word, 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
